// File: rtl/game_pkg.sv
// Shared cell/winner codes and controller state encoding for the N x N game controller.
package game_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    P_WAIT,
    P_CHECK,
    AI_REQ,
    AI_WAIT,
    AI_CHECK,
    DONE
  } game_state_e;

endpackage

// File: rtl/win_detect.sv
// Combinational N-in-a-row detector: flags a complete row, column or diagonal
// of X (x_line) or of O (o_line) on the packed board.
module win_detect
  import game_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2*N*N-1:0] board,
  output logic             x_line,
  output logic             o_line
);

  localparam int CELLS = N * N;

  function automatic logic line_full(input logic [2*CELLS-1:0] b, input int start,
                                     input int step, input logic [1:0] code);
    logic hit;
    hit = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (b[2*(start+k*step) +: 2] != code) hit = 1'b0;
    end
    return hit;
  endfunction

  function automatic logic any_line(input logic [2*CELLS-1:0] b, input logic [1:0] code);
    logic found;
    found = line_full(b, 0, N + 1, code) | line_full(b, N - 1, N - 1, code);
    for (int i = 0; i < N; i++) begin
      found = found | line_full(b, i * N, 1, code) | line_full(b, i, N, code);
    end
    return found;
  endfunction

  assign x_line = any_line(board, CELL_X);
  assign o_line = any_line(board, CELL_O);

endmodule

// File: rtl/game_fsm_nxn.sv
// N x N tic-tac-toe match controller with move validation and AI handshake.
// Optional AI ack timeout with lowest-free-cell fallback: define GAME_AI_TIMEOUT_EN.
module game_fsm_nxn
  import game_pkg::*;
#(
  parameter  int N          = 3,
  parameter  int AI_TIMEOUT = 255,
  localparam int CELLS      = N * N,
  localparam int IDX_W      = $clog2(CELLS),
  localparam int CNT_W      = $clog2(CELLS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_game,
  input  logic               two_player,
  input  logic [IDX_W-1:0]   p_tick,
  input  logic               p_confirm,
  input  logic [IDX_W-1:0]   ai_tick,
  input  logic               ai_ack,
  output logic               ai_confirm,
  output logic [2*CELLS-1:0] cell_position,
  output logic [1:0]         winner,
  output logic               player_turn,
  output logic [CNT_W-1:0]   move_cnt,
  output logic               illegal_move,
  output game_state_e        dbg_state
);

  // ai_confirm is a one-cycle request; ai_ack is a one-cycle reply whose ai_tick
  // is only looked at while waiting in AI_WAIT. Strobes in other states are dropped.

  if (N < 3 || N > 8 || AI_TIMEOUT < 1) begin : g_param_check
    $error("game_fsm_nxn: N must be 3..8 and AI_TIMEOUT >= 1");
  end

  game_state_e        state_q, state_d;
  logic [2*CELLS-1:0] board_q, board_d;
  logic [1:0]         winner_q, winner_d;
  logic               turn_q, turn_d;
  logic               tp_q, tp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ai_confirm_q, ai_confirm_d;
  logic               illegal_q, illegal_d;
  logic               x_line, o_line;
  logic [1:0]         win_eval;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [1:0]         wr_code;

  win_detect #(.N(N)) u_win (
    .board  (board_q),
    .x_line (x_line),
    .o_line (o_line)
  );

  // Out-of-range indices never match a cell, so they read as occupied.
  function automatic logic cell_free(input logic [2*CELLS-1:0] b, input logic [IDX_W-1:0] idx);
    logic free;
    free = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (idx == IDX_W'(i)) free = (b[2*i +: 2] == CELL_EMPTY);
    end
    return free;
  endfunction

  always_comb begin
    if (x_line)                       win_eval = WIN_X;
    else if (o_line)                  win_eval = WIN_O;
    else if (cnt_q == CNT_W'(CELLS))  win_eval = WIN_DRAW;
    else                              win_eval = WIN_NONE;
  end

`ifdef GAME_AI_TIMEOUT_EN
  localparam int TMO_W = $clog2(AI_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [IDX_W-1:0] free_idx;

  always_comb begin
    free_idx = '0;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (board_q[2*i +: 2] == CELL_EMPTY) free_idx = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    winner_d  = winner_q;
    turn_d    = turn_q;
    tp_d      = tp_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_code   = CELL_X;
`ifdef GAME_AI_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      P_WAIT: begin
        if (p_confirm) begin
          if (cell_free(board_q, p_tick)) begin
            wr_en   = 1'b1;
            wr_idx  = p_tick;
            wr_code = (two_player && !turn_q) ? CELL_O : CELL_X;
            tp_d    = two_player;
            state_d = P_CHECK;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      P_CHECK, AI_CHECK: begin
        winner_d = win_eval;
        if (win_eval != WIN_NONE) begin
          state_d = DONE;
        end else if (state_q == P_CHECK && tp_q) begin
          turn_d  = !turn_q;
          state_d = P_WAIT;
        end else if (state_q == P_CHECK) begin
          turn_d  = 1'b0;
          state_d = AI_REQ;
        end else begin
          turn_d  = 1'b1;
          state_d = P_WAIT;
        end
      end
      AI_REQ: begin
        state_d = AI_WAIT;
`ifdef GAME_AI_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      AI_WAIT: begin
        if (ai_ack) begin
          if (cell_free(board_q, ai_tick)) begin
            wr_en   = 1'b1;
            wr_idx  = ai_tick;
            wr_code = CELL_O;
            state_d = AI_CHECK;
          end else begin
            illegal_d = 1'b1;
            state_d   = AI_REQ;
          end
        end
`ifdef GAME_AI_TIMEOUT_EN
        else if (tmo_q == TMO_W'(AI_TIMEOUT - 1)) begin
          wr_en   = 1'b1;
          wr_idx  = free_idx;
          wr_code = CELL_O;
          state_d = AI_CHECK;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = DONE;
      default: state_d = P_WAIT;
    endcase

    if (wr_en) begin
      for (int i = 0; i < CELLS; i++) begin
        if (wr_idx == IDX_W'(i)) board_d[2*i +: 2] = wr_code;
      end
      cnt_d = cnt_q + 1'b1;
    end

    // A clear request overrides any move accepted in the same cycle.
    if (new_game) begin
      state_d   = P_WAIT;
      board_d   = '0;
      winner_d  = WIN_NONE;
      turn_d    = 1'b1;
      tp_d      = 1'b0;
      cnt_d     = '0;
      illegal_d = 1'b0;
    end

    ai_confirm_d = (state_d == AI_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= P_WAIT;
      board_q      <= '0;
      winner_q     <= WIN_NONE;
      turn_q       <= 1'b1;
      tp_q         <= 1'b0;
      cnt_q        <= '0;
      ai_confirm_q <= 1'b0;
      illegal_q    <= 1'b0;
`ifdef GAME_AI_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      winner_q     <= winner_d;
      turn_q       <= turn_d;
      tp_q         <= tp_d;
      cnt_q        <= cnt_d;
      ai_confirm_q <= ai_confirm_d;
      illegal_q    <= illegal_d;
`ifdef GAME_AI_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign ai_confirm    = ai_confirm_q;
  assign cell_position = board_q;
  assign winner        = winner_q;
  assign player_turn   = turn_q;
  assign move_cnt      = cnt_q;
  assign illegal_move  = illegal_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_game_fsm_nxn.sv
// Bench for game_fsm_nxn (N=3): directed test-plan games plus random games,
// checked against a cell-array reference model through an expected-snapshot queue.
module tb_game_fsm_nxn;
  import game_pkg::*;

  localparam int N      = 3;
  localparam int AI_TO  = 10;
  localparam int CELLS  = N * N;
  localparam int IDX_W  = $clog2(CELLS);
  localparam int CNT_W  = $clog2(CELLS + 1);
  localparam int W      = 2 * CELLS + 2 + 1 + CNT_W + 2;

  logic               clk;
  logic               rst;
  logic               new_game;
  logic               two_player;
  logic [IDX_W-1:0]   p_tick;
  logic               p_confirm;
  logic [IDX_W-1:0]   ai_tick;
  logic               ai_ack;
  logic               ai_confirm;
  logic [2*CELLS-1:0] cell_position;
  logic [1:0]         winner;
  logic               player_turn;
  logic [CNT_W-1:0]   move_cnt;
  logic               illegal_move;
  game_state_e        dbg_state;

  game_fsm_nxn #(.N(N), .AI_TIMEOUT(AI_TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .new_game      (new_game),
    .two_player    (two_player),
    .p_tick        (p_tick),
    .p_confirm     (p_confirm),
    .ai_tick       (ai_tick),
    .ai_ack        (ai_ack),
    .ai_confirm    (ai_confirm),
    .cell_position (cell_position),
    .winner        (winner),
    .player_turn   (player_turn),
    .move_cnt      (move_cnt),
    .illegal_move  (illegal_move),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         mb[CELLS];   // 0 empty, 1 X, 2 O
  logic [1:0] m_winner;
  logic       m_turn;
  int         m_cnt;

  function automatic logic [1:0] ref_winner();
    for (int p = 1; p <= 2; p++) begin
      int rc[N];
      int cc[N];
      int d1;
      int d2;
      d1 = 0;
      d2 = 0;
      for (int i = 0; i < N; i++) begin
        rc[i] = 0;
        cc[i] = 0;
      end
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (mb[r*N+c] == p) begin
            rc[r]++;
            cc[c]++;
            if (r == c) d1++;
            if (r + c == N - 1) d2++;
          end
      if (d1 == N || d2 == N) return 2'(p);
      for (int i = 0; i < N; i++)
        if (rc[i] == N || cc[i] == N) return 2'(p);
    end
    return (m_cnt == CELLS) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [W-1:0] ref_snap(input logic ill, input logic aic);
    logic [2*CELLS-1:0] bb;
    bb = '0;
    for (int i = 0; i < CELLS; i++) bb[2*i +: 2] = 2'(mb[i]);
    return {bb, m_winner, m_turn, CNT_W'(m_cnt), ill, aic};
  endfunction

  function automatic logic [W-1:0] dut_snap();
    return {cell_position, winner, player_turn, move_cnt, illegal_move, ai_confirm};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < CELLS; i++) mb[i] = 0;
    m_winner = 2'b00;
    m_turn   = 1'b1;
    m_cnt    = 0;
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h expected %h", name, act, exp);
    end
  endtask

  // Compares a snapshot when illegal_move pulses or one cycle after move_cnt grows.
  initial begin : monitor
    int prev_cnt;
    bit pending;
    prev_cnt = 0;
    pending  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cnt = 0;
        pending  = 0;
      end else begin
        if (pending || illegal_move) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: actual %h expected none", dut_snap());
          end else begin
            check("event_snapshot", dut_snap(), exp_q.pop_front());
          end
        end
        pending  = (int'(move_cnt) > prev_cnt);
        prev_cnt = int'(move_cnt);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_new_game(input logic with_confirm, input int idx);
    new_game  = 1'b1;
    p_confirm = with_confirm;
    p_tick    = IDX_W'(idx);
    @(negedge clk);
    new_game  = 1'b0;
    p_confirm = 1'b0;
    m_reset();
    check("new_game_state", dut_snap(), ref_snap(1'b0, 1'b0));
  endtask

  task automatic player_move(input int idx, output bit legal);
    legal     = (idx < CELLS) && (mb[idx] == 0);
    p_tick    = IDX_W'(idx);
    p_confirm = 1'b1;
    if (legal) begin
      mb[idx]  = (two_player && !m_turn) ? 2 : 1;
      m_cnt++;
      m_winner = ref_winner();
      if (m_winner == 2'b00) m_turn = two_player ? !m_turn : 1'b0;
      exp_q.push_back(ref_snap(1'b0, (m_winner == 2'b00) && !two_player));
    end else begin
      exp_q.push_back(ref_snap(1'b1, 1'b0));
    end
    @(negedge clk);
    p_confirm = 1'b0;
    @(negedge clk);
  endtask

  task automatic ai_reply(input int idx, input int delay, output bit legal);
    int t;
    t     = 0;
    legal = 1'b0;
    while (!ai_confirm && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ai_confirm_seen", W'(ai_confirm), W'(1));
    if (!ai_confirm) return;
    @(negedge clk);
    repeat (delay) @(negedge clk);
    legal   = (idx < CELLS) && (mb[idx] == 0);
    ai_tick = IDX_W'(idx);
    ai_ack  = 1'b1;
    if (legal) begin
      mb[idx]  = 2;
      m_cnt++;
      m_winner = ref_winner();
      if (m_winner == 2'b00) m_turn = 1'b1;
      exp_q.push_back(ref_snap(1'b0, 1'b0));
    end else begin
      exp_q.push_back(ref_snap(1'b1, 1'b1));
    end
    @(negedge clk);
    ai_ack = 1'b0;
    if (legal) @(negedge clk);
  endtask

  // Strobes that must change nothing (used in DONE).
  task automatic strobe_ignored(input int idx);
    p_tick    = IDX_W'(idx);
    ai_tick   = IDX_W'(idx);
    p_confirm = 1'b1;
    ai_ack    = 1'b1;
    @(negedge clk);
    p_confirm = 1'b0;
    ai_ack    = 1'b0;
    repeat (3) @(negedge clk);
    check("done_holds", dut_snap(), ref_snap(1'b0, 1'b0));
  endtask

  // ---------------- stimulus ----------------
  int  two_moves[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
  int  anti_moves[5] = '{2, 0, 4, 1, 6};

  initial begin : stimulus
    bit ok;
    rst        = 1'b1;
    new_game   = 1'b0;
    two_player = 1'b0;
    p_tick     = '0;
    p_confirm  = 1'b0;
    ai_tick    = '0;
    ai_ack     = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_state", dut_snap(), ref_snap(1'b0, 1'b0));

    // X wins top row against the AI stub.
    player_move(0, ok);
    ai_reply(4, 0, ok);
    player_move(1, ok);
    ai_reply(5, 1, ok);
    player_move(2, ok);
    check("row_win_bits", W'(cell_position[5:0]), W'(6'b010101));
    check("row_win_winner", W'(winner), W'(WIN_X));
    strobe_ignored(6);

    // Occupied cell rejected.
    do_new_game(1'b0, 0);
    player_move(4, ok);
    ai_reply(0, 0, ok);
    player_move(0, ok);
    check("occupied_cnt", W'(move_cnt), W'(2));
    check("occupied_turn", W'(player_turn), W'(1));

    // AI answers an occupied cell, gets re-requested, then answers legally.
    do_new_game(1'b0, 0);
    player_move(0, ok);
    ai_reply(0, 0, ok);
    ai_reply(4, 2, ok);
    check("ai_retry_cnt", W'(move_cnt), W'(2));

    // Two-player draw.
    two_player = 1'b1;
    do_new_game(1'b0, 0);
    foreach (two_moves[i]) player_move(two_moves[i], ok);
    check("draw_winner", W'(winner), W'(WIN_DRAW));
    check("draw_cnt", W'(move_cnt), W'(CELLS));

    // Two-player anti-diagonal win, then new_game colliding with p_confirm.
    do_new_game(1'b0, 0);
    foreach (anti_moves[i]) player_move(anti_moves[i], ok);
    check("anti_winner", W'(winner), W'(WIN_X));
    do_new_game(1'b1, 4);
    player_move(7, ok);
    do_new_game(1'b1, 3);

    // Random games, including out-of-range and occupied picks.
    for (int g = 0; g < 8; g++) begin
      int guard;
      two_player = 1'($urandom_range(0, 1));
      do_new_game(1'b0, 0);
      guard = 0;
      while (m_winner == 2'b00 && guard < 80) begin
        guard++;
        player_move($urandom_range(0, (1 << IDX_W) - 1), ok);
        if (ok && !two_player && m_winner == 2'b00) begin
          bit ai_ok;
          int tries;
          ai_ok = 1'b0;
          tries = 0;
          while (!ai_ok && tries < 10) begin
            int pick;
            pick = $urandom_range(0, (1 << IDX_W) - 1);
            if (tries >= 3)
              for (int i = CELLS - 1; i >= 0; i--) if (mb[i] == 0) pick = i;
            ai_reply(pick, $urandom_range(0, 3), ai_ok);
            tries++;
          end
        end
      end
      check("random_game_over", W'(m_winner != 2'b00), W'(1));
    end

`ifdef GAME_AI_TIMEOUT_EN
    begin
      int lat;
      two_player = 1'b0;
      do_new_game(1'b0, 0);
      player_move(0, ok);
      mb[1]    = 2;
      m_cnt++;
      m_winner = ref_winner();
      m_turn   = 1'b1;
      exp_q.push_back(ref_snap(1'b0, 1'b0));
      lat = 0;
      while (int'(move_cnt) != 2 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check("timeout_latency", W'(lat >= AI_TO - 1 && lat <= AI_TO + 2), W'(1));
      repeat (2) @(negedge clk);
    end
`endif

    repeat (4) @(negedge clk);
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
